booth_multiplier: RTL and testbench
===================================

// Module: booth_multiplier
// PURPOSE
//  Sequential signed radix-2 Booth multiplier for two's-complement N-bit operands.
//  A single-cycle start pulse launches one multiplication. The 2N-bit signed product
//  is produced after N iteration cycles and flagged by a one-cycle done pulse.
//  Standalone arithmetic leaf. One operation in flight at a time.
// PARAMETERS
//  N  8  operand width in bits, signed; legal N >= 2; product is 2N bits
// PORTS
//  clk           in   1    single clock; all state updates on the rising edge
//  rst           in   1    reset; asynchronous, active-low (rst==0 resets)
//  start         in   1    request; sampled only in IDLE
//  multiplicand  in   N    signed operand M; captured on the accepted start edge
//  multiplier    in   N    signed operand Q; captured on the accepted start edge
//  product       out  2N   signed result M*Q; registered
//  done          out  1    one-cycle pulse; product is valid in the same cycle
// BEHAVIOUR
//  - Reset (rst low, any time, asynchronous):
//    state=IDLE, product=0, done=0, all internal registers 0.
//    Reset mid-operation aborts the operation; there is no partial result.
//  - States: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE, start==1 at an edge: load
//    A=0 (N+1 bits), Qr=multiplier, q_1=0, Mr=sign-extended multiplicand (N+1 bits), cnt=N.
//    Go to BUSY.
//  - IDLE, start==0: hold all state. product keeps its last value; done=0.
//  - BUSY, each edge:
//    {Qr[0],q_1}: 01 -> A+=Mr; 10 -> A-=Mr; 00/11 -> no add.
//    Then arithmetic right shift {A,Qr,q_1} by 1; cnt-=1.
//    After the N-th BUSY edge go to DONE.
//  - DONE edge: product <= {A[N-1:0],Qr}; done <= 1 for exactly one cycle; go to IDLE.
//  - Latency: accepted start at edge k -> done high in the cycle after edge k+N+1,
//    i.e. 9 cycles for N=8. Product is valid from the done cycle.
//  - product is held stable until the next completion or reset.
//  - start during BUSY/DONE is ignored and never queued. Operand changes after the
//    accepted edge have no effect.
//  - start held high continuously gives back-to-back operations: re-accepted in the
//    IDLE cycle right after done.
//  - Arithmetic is exact for all operand pairs, including -2^(N-1) * -2^(N-1) = +2^(2N-2).
//    The N+1-bit accumulator prevents negation overflow. No overflow flag.
// STRUCTURE
//  - Shared package booth_pkg: state enum {IDLE,BUSY,DONE}; count width $clog2(N+1).
//  - Sub-module booth_step (combinational): inputs A, Qr, q_1, Mr; outputs the next
//    shifted {A,Qr,q_1}.
//  - Top: FSM, counter, operand and result registers.
// TESTING
//  - Release rst, start with M=-5, Q=3 -> done after 9 cycles; product=16'hFFF1 (-15).
//  - M=-128, Q=-128 -> 16'h4000 (16384); M=127, Q=-128 -> 16'hC080 (-16256).
//  - M=0, Q=-77 -> product 0; M=-1, Q=-1 -> product 1; M=127, Q=127 -> 16'h3F01.
//  - start pulsed and operands changed during BUSY -> ignored; result from the first
//    operands; exactly one done pulse.
//  - rst low mid-BUSY -> product=0, done=0 immediately.
//    The next start completes normally in 9 cycles.
//  - start held high -> consecutive done pulses 10 cycles apart.
//    Random signed sweep versus a reference model.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Operation chosen by the current multiplier bit pair {Qr[0], q_1}.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB
    } op_e;

    // Width of an iteration counter that has to hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Booth recoding: 01 adds M, 10 subtracts M, 00/11 leave A alone.
    function automatic op_e booth_op(input logic q0, input logic q_1);
        op_e op;
        unique case ({q0, q_1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/subtract of Mr into A, then an
// arithmetic right shift of the concatenation {A, Qr, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] qr,
    input  logic         q_1,
    input  logic [N:0]   mr,
    output logic [N:0]   a_next,
    output logic [N-1:0] qr_next,
    output logic         q_1_next
);

    logic [N:0] sum;

    // Add or subtract the multiplicand according to the recoded bit pair.
    always_comb begin
        sum = a;
        unique case (booth_op(qr[0], q_1))
            OP_ADD:  sum = a + mr;
            OP_SUB:  sum = a - mr;
            default: sum = a;
        endcase
    end

    // Arithmetic right shift of {sum, qr, q_1}; the sign of A is replicated.
    always_comb begin
        a_next   = {sum[N], sum[N:1]};
        qr_next  = {sum[0], qr[N-1:1]};
        q_1_next = qr[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier. One start pulse launches an
// N-iteration multiply; the 2N-bit product is registered with a done pulse.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           done
);

    localparam int unsigned CW = cnt_width(N);

    state_e         state_q, state_d;
    logic [N:0]     a_q, a_d;
    logic [N-1:0]   qr_q, qr_d;
    logic           q1_q, q1_d;
    logic [N:0]     mr_q, mr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic           done_q, done_d;

    logic [N:0]     a_step;
    logic [N-1:0]   qr_step;
    logic           q1_step;

    booth_step #(
        .N (N)
    ) u_step (
        .a        (a_q),
        .qr       (qr_q),
        .q_1      (q1_q),
        .mr       (mr_q),
        .a_next   (a_step),
        .qr_next  (qr_step),
        .q_1_next (q1_step)
    );

    // Next-state logic: load operands, iterate N times, then publish the result.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        qr_d      = qr_q;
        q1_d      = q1_q;
        mr_d      = mr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    // One extra accumulator bit keeps -(-2^(N-1)) representable.
                    mr_d    = {multiplicand[N-1], multiplicand};
                    cnt_d   = CW'(N);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d   = a_step;
                qr_d  = qr_step;
                q1_d  = q1_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                product_d = {a_q[N-1:0], qr_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            qr_q      <= '0;
            q1_q      <= 1'b0;
            mr_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            qr_q      <= qr_d;
            q1_q      <= q1_d;
            mr_q      <= mr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed literal cases plus a
// random signed sweep, with a cycle-level reference model checked every cycle.
module tb_booth_multiplier;

    localparam int unsigned N   = 8;
    localparam int unsigned LAT = N + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   multiplicand = '0;
    logic [N-1:0]   multiplier = '0;
    logic [2*N-1:0] product;
    logic           done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_multiplier #(
        .N (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .done         (done)
    );

    function automatic logic [2*N-1:0] prod_of(input logic [N-1:0] m, input logic [N-1:0] q);
        longint p;
        p = longint'($signed(m)) * longint'($signed(q));
        return p[2*N-1:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start completes N+1 edges later with the exact
    // signed product; starts while an operation is pending are dropped.
    logic           m_busy;
    longint         m_edge;
    longint         m_done_at;
    logic [2*N-1:0] m_pend;
    logic [2*N-1:0] m_prod;
    logic           m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy    <= 1'b0;
            m_edge    <= 0;
            m_done_at <= 0;
            m_pend    <= '0;
            m_prod    <= '0;
            m_done    <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_edge == m_done_at) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= m_pend;
                end
            end else if (start) begin
                m_busy    <= 1'b1;
                m_done_at <= m_edge + LAT;
                m_pend    <= prod_of(multiplicand, multiplier);
            end
        end
    end

    // Every cycle out of reset, outputs must match the model.
    always @(negedge clk) begin
        if (rst) begin
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_product", 32'(product), 32'(m_prod));
        end
    end

    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                          input logic [2*N-1:0] exp, input string nm);
        int lat;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(LAT));
        check(nm, 32'(product), 32'(exp));
    endtask

    initial begin
        int pulses;
        int gap;
        logic [2*N-1:0] seen;
        logic [N-1:0] rm, rq;

        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int gap;
        logic [2*N-1:0] seen;
        logic [N-1:0] rm, rq;

        // Pin the model against hand-computed products.
        check("model_min_min", 32'(prod_of(8'h80, 8'h80)), 32'h4000);
        check("model_m1_m1", 32'(prod_of(8'hFF, 8'hFF)), 32'h0001);
        check("model_m5_3", 32'(prod_of(8'hFB, 8'h03)), 32'hFFF1);

        repeat (3) @(negedge clk);
        check("reset_product", 32'(product), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b1;

        run_op(8'hFB, 8'h03, 16'hFFF1, "m5_x_3");
        run_op(8'h80, 8'h80, 16'h4000, "min_x_min");
        run_op(8'h7F, 8'h80, 16'hC080, "max_x_min");
        run_op(8'h00, 8'hB3, 16'h0000, "zero_x_m77");
        run_op(8'hFF, 8'hFF, 16'h0001, "m1_x_m1");
        run_op(8'h7F, 8'h7F, 16'h3F01, "max_x_max");

        // Start pulsed with new operands while busy must be ignored.
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd6;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        multiplicand = 8'h55;
        multiplier   = 8'h33;
        start        = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        seen   = '0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                seen = product;
            end
        end
        check("busy_start_pulses", 32'(pulses), 32'd1);
        check("busy_start_product", 32'(seen), 32'd42);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        multiplicand = 8'd100;
        multiplier   = 8'hFD;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_product", 32'(product), 32'h0);
        check("midreset_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run_op(8'd12, 8'hF5, 16'hFF7C, "after_reset");

        // Start held high: back-to-back operations 10 cycles apart.
        @(negedge clk);
        multiplicand = 8'd9;
        multiplier   = 8'hF7;
        start        = 1'b1;
        gap = 0;
        while (done !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        check("held_first_product", 32'(product), 32'hFFAF);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (done !== 1'b1 && gap < 40);
        start = 1'b0;
        check("held_gap", 32'(gap), 32'd10);
        check("held_second_product", 32'(product), 32'hFFAF);
        repeat (15) @(negedge clk);

        // Random signed sweep.
        for (int i = 0; i < 40; i++) begin
            rm = N'($urandom);
            rq = N'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(rm, rq, prod_of(rm, rq), "random");
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
